// File: rtl/dev_csr_pkg.sv
// Shared types for the dev CSR initiator: command record, FSM state encoding
// and the fixed counter width.
package dev_csr_pkg;

    localparam int REG_COUNT   = 8;
    localparam int REG_DATA_W  = 32;
    localparam int REG_ADDR_W  = $clog2(REG_COUNT);
    localparam int CMD_DEPTH   = 4;
    localparam int STRAY_CNT_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wr_data;
        logic                  wr_en;
    } csr_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        HOST_RSP
    } csr_init_state_e;

endpackage

// File: rtl/dev_csr_cmd_fifo.sv
// Synchronous command FIFO of csr_cmd_t. Pointers carry one extra wrap bit so
// full and empty are told apart by comparing the MSBs.
module dev_csr_cmd_fifo
    import dev_csr_pkg::*;
#(
    parameter int Depth = CMD_DEPTH
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  csr_cmd_t data_i,
    input  logic     pop_i,
    output csr_cmd_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(Depth);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    csr_cmd_t    mem_q [Depth];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/dev_csr_initiator.sv
// Requester side of the dev CSR manager interface: queues host commands, keeps
// one CSR transaction outstanding and returns read data (or a timeout error).
module dev_csr_initiator
    import dev_csr_pkg::*;
#(
    parameter int RegCount      = REG_COUNT,
    parameter int RegDataWidth  = REG_DATA_W,
    parameter int RegAddrWidth  = $clog2(RegCount),
    parameter int CmdDepth      = CMD_DEPTH,
    parameter int TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [RegAddrWidth-1:0] host_addr_i,
    input  logic [RegDataWidth-1:0] host_wr_data_i,
    input  logic                    host_wr_en_i,
    input  logic                    host_valid_i,
    output logic                    host_ready_o,
    output logic [RegDataWidth-1:0] host_rd_data_o,
    output logic                    host_rsp_err_o,
    output logic                    host_rsp_valid_o,
    input  logic                    host_rsp_ready_i,
    output logic [RegAddrWidth-1:0] csr_addr_o,
    output logic [RegDataWidth-1:0] csr_wr_data_o,
    output logic                    csr_wr_en_o,
    output logic                    csr_req_valid_o,
    input  logic                    csr_req_ready_i,
    input  logic [RegDataWidth-1:0] csr_rd_data_i,
    input  logic                    csr_rsp_valid_i,
    output logic                    csr_rsp_ready_o,
    output logic                    busy_o,
    output logic [STRAY_CNT_W-1:0]  stray_cnt_o,
    output csr_init_state_e         state_o
);

    localparam int TO_W = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    // Every channel uses valid/ready: a transfer happens on the rising clock
    // edge where both are high; the sender holds valid and payload stable
    // until then, and valid never depends combinationally on ready.

    csr_init_state_e        state_q, state_d;
    csr_cmd_t               cmd_in, fifo_head, req_q;
    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [TO_W-1:0]        to_cnt_q;
    logic [RegDataWidth-1:0] rsp_data_q;
    logic                   rsp_err_q;
    logic [STRAY_CNT_W-1:0] stray_q;
    logic                   timeout_hit, stray_hit;

    assign cmd_in.addr    = host_addr_i;
    assign cmd_in.wr_data = host_wr_data_i;
    assign cmd_in.wr_en   = host_wr_en_i;

    dev_csr_cmd_fifo #(
        .Depth (CmdDepth)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (host_valid_i),
        .data_i  (cmd_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign timeout_hit = (TimeoutCycles != 0) && (int'(to_cnt_q) == TimeoutCycles - 1);
    assign stray_hit   = csr_rsp_valid_i && ((state_q == IDLE) || (state_q == REQ));

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (csr_req_ready_i) begin
                    state_d = req_q.wr_en ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (csr_rsp_valid_i || timeout_hit) begin
                    state_d = HOST_RSP;
                end
            end
            HOST_RSP: begin
                if (host_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= '0;
            to_cnt_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            stray_q    <= '0;
        end else begin
            if (fifo_pop) begin
                req_q <= fifo_head;
            end
            if (state_q == REQ && csr_req_ready_i) begin
                to_cnt_q <= '0;
            end
            // A response arriving in the timeout cycle wins over the timeout.
            if (state_q == WAIT_RSP) begin
                if (csr_rsp_valid_i) begin
                    rsp_data_q <= csr_rd_data_i;
                    rsp_err_q  <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end
            if (stray_hit && (stray_q != '1)) begin
                stray_q <= stray_q + STRAY_CNT_W'(1);
            end
        end
    end

    assign host_ready_o     = !fifo_full;
    assign host_rd_data_o   = rsp_data_q;
    assign host_rsp_err_o   = rsp_err_q;
    assign host_rsp_valid_o = (state_q == HOST_RSP);
    assign csr_addr_o       = req_q.addr;
    assign csr_wr_data_o    = req_q.wr_data;
    assign csr_wr_en_o      = req_q.wr_en;
    assign csr_req_valid_o  = (state_q == REQ);
    assign csr_rsp_ready_o  = (state_q != HOST_RSP);
    assign busy_o           = !fifo_empty || (state_q != IDLE);
    assign stray_cnt_o      = stray_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_dev_csr_initiator.sv
// Randomized scoreboard bench for dev_csr_initiator with a responder model,
// a program-order register model and a decoupled output monitor.
module tb_dev_csr_initiator;

    localparam int TO = 8;

    logic        clk, rst_n;
    logic [2:0]  host_addr;
    logic [31:0] host_wr_data;
    logic        host_wr_en, host_valid, host_ready;
    logic [31:0] host_rd_data;
    logic        host_rsp_err, host_rsp_valid, host_rsp_ready;
    logic [2:0]  csr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wr_en, csr_req_valid, csr_req_ready;
    logic [31:0] csr_rd_data;
    logic        csr_rsp_valid, csr_rsp_ready;
    logic        busy;
    logic [7:0]  stray_cnt;
    dev_csr_pkg::csr_init_state_e dbg_state;

    dev_csr_initiator #(.TimeoutCycles(TO)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .host_addr_i      (host_addr),
        .host_wr_data_i   (host_wr_data),
        .host_wr_en_i     (host_wr_en),
        .host_valid_i     (host_valid),
        .host_ready_o     (host_ready),
        .host_rd_data_o   (host_rd_data),
        .host_rsp_err_o   (host_rsp_err),
        .host_rsp_valid_o (host_rsp_valid),
        .host_rsp_ready_i (host_rsp_ready),
        .csr_addr_o       (csr_addr),
        .csr_wr_data_o    (csr_wr_data),
        .csr_wr_en_o      (csr_wr_en),
        .csr_req_valid_o  (csr_req_valid),
        .csr_req_ready_i  (csr_req_ready),
        .csr_rd_data_i    (csr_rd_data),
        .csr_rsp_valid_i  (csr_rsp_valid),
        .csr_rsp_ready_o  (csr_rsp_ready),
        .busy_o           (busy),
        .stray_cnt_o      (stray_cnt),
        .state_o          (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- shared state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [35:0] exp_req_q[$];   // {wr_en, addr, wr_data}
    logic [32:0] exp_rsp_q[$];   // {err, data}
    int          exp_lat_q[$];   // req handshake to host_rsp_valid, in cycles
    int          delay_q[$];     // responder reply cycle per read
    logic [31:0] model_mem [8];
    logic [31:0] resp_mem [8];
    int          exp_stray = 0;
    logic        hold_req = 1'b0;
    logic        resp_busy = 1'b0;
    logic        sink_block = 1'b0;
    logic        rand_sink = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_cmd(input logic wr, input logic [2:0] a, input logic [31:0] d, input int dly);
        int n = 0;
        if (wr) begin
            model_mem[a] = d;
        end else begin
            delay_q.push_back(dly);
            if (dly <= TO) begin
                exp_rsp_q.push_back({1'b0, model_mem[a]});
                exp_lat_q.push_back(dly);
            end else begin
                exp_rsp_q.push_back({1'b1, 32'h0});
                exp_lat_q.push_back(TO);
                exp_stray++;
            end
        end
        exp_req_q.push_back({wr, a, d});
        host_addr = a; host_wr_data = d; host_wr_en = wr; host_valid = 1'b1;
        while (!host_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) check("push_wait_budget", 64'(n), 64'(0));
        @(posedge clk); #1;
        host_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || resp_busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check({tag, "_idle_budget"}, 64'(n), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_stray"}, 64'(stray_cnt), 64'(exp_stray));
    endtask

    // ---------------- responder model ----------------
    initial begin : responder
        logic [2:0]  r_addr;
        logic [31:0] r_data;
        logic        r_wr;
        int          d, n;
        csr_req_ready = 1'b0; csr_rsp_valid = 1'b0; csr_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && csr_req_valid && !hold_req) begin
                resp_busy = 1'b1;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                r_addr = csr_addr; r_wr = csr_wr_en; r_data = csr_wr_data;
                csr_req_ready = 1'b1;
                @(posedge clk); #1;
                csr_req_ready = 1'b0;
                if (r_wr) begin
                    resp_mem[r_addr] = r_data;
                end else begin
                    d = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
                    repeat (d - 1) begin @(posedge clk); #1; end
                    csr_rsp_valid = 1'b1;
                    csr_rd_data = resp_mem[r_addr];
                    n = 0;
                    while (!csr_rsp_ready && n < 300) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (n >= 300) check("rsp_ready_budget", 64'(n), 64'(0));
                    @(posedge clk); #1;
                    csr_rsp_valid = 1'b0;
                    csr_rd_data = '0;
                end
                resp_busy = 1'b0;
            end
        end
    end

    initial begin : host_sink
        host_rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sink_block) host_rsp_ready = 1'b0;
            else if (rand_sink) host_rsp_ready = ($urandom_range(0, 2) != 0);
            else host_rsp_ready = 1'b1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        int   pushed = 0, issued = 0, req_edge = 0, chk_at = -10;
        logic prev_hv = 0, prev_hblk = 0, prev_rblk = 0;
        logic [32:0] prev_h;
        logic [35:0] prev_r, e_r;
        logic [32:0] e_h;
        int   e_l;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pushed = 0; issued = 0; chk_at = -10;
                prev_hv = 0; prev_hblk = 0; prev_rblk = 0;
                continue;
            end
            if (host_valid && host_ready) pushed++;
            if (prev_rblk) begin
                check("req_hold_valid", 64'(csr_req_valid), 64'(1));
                check("req_hold_payload", 64'({csr_wr_en, csr_addr, csr_wr_data}), 64'(prev_r));
            end
            if (csr_req_valid && csr_req_ready) begin
                issued++;
                if (exp_req_q.size() == 0) begin
                    check("req_unexpected", 64'(1), 64'(0));
                end else begin
                    e_r = exp_req_q.pop_front();
                    check("req_payload", 64'({csr_wr_en, csr_addr, csr_wr_data}), 64'(e_r));
                end
                if (!csr_wr_en) req_edge = cyc + 1;
            end
            if (host_rsp_valid && !prev_hv) begin
                e_l = (exp_lat_q.size() > 0) ? exp_lat_q.pop_front() : -1;
                check("rsp_latency", 64'(cyc - req_edge), 64'(e_l));
            end
            if (host_rsp_valid) begin
                check("rsp_ready_low_in_host_rsp", 64'(csr_rsp_ready), 64'(0));
                check("no_req_in_host_rsp", 64'(csr_req_valid), 64'(0));
            end
            if (prev_hblk) begin
                check("rsp_hold", 64'({host_rsp_valid, host_rsp_err, host_rd_data}), 64'({1'b1, prev_h}));
            end
            if (host_rsp_valid && host_rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e_h = exp_rsp_q.pop_front();
                    check("rsp_data", 64'({host_rsp_err, host_rd_data}), 64'(e_h));
                end
                if (pushed > issued) chk_at = cyc + 2;
            end
            if (cyc == chk_at - 1) check("next_issue_not_early", 64'(csr_req_valid), 64'(0));
            if (cyc == chk_at) check("next_issue_after_rsp", 64'(csr_req_valid), 64'(1));
            prev_hv   = host_rsp_valid;
            prev_hblk = host_rsp_valid && !host_rsp_ready;
            prev_h    = {host_rsp_err, host_rd_data};
            prev_rblk = csr_req_valid && !csr_req_ready;
            prev_r    = {csr_wr_en, csr_addr, csr_wr_data};
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [31:0] snap [8];
        int r, dly;
        for (int i = 0; i < 8; i++) begin model_mem[i] = '0; resp_mem[i] = '0; end
        host_addr = '0; host_wr_data = '0; host_wr_en = 1'b0; host_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_host_ready", 64'(host_ready), 64'(1));
        check("rst_csr_rsp_ready", 64'(csr_rsp_ready), 64'(1));
        check("rst_valids_busy", 64'({csr_req_valid, host_rsp_valid, busy}), 64'(0));
        check("rst_rsp_out", 64'({host_rsp_err, host_rd_data}), 64'(0));
        check("rst_req_out", 64'({csr_wr_en, csr_addr, csr_wr_data}), 64'(0));
        check("rst_stray", 64'(stray_cnt), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write then read back, with issue latency from an empty FIFO
        do_cmd(1'b1, 3'd3, 32'hDEADBEEF, 0);
        check("issue_lat_c1", 64'(csr_req_valid), 64'(0));
        @(posedge clk); #1;
        check("issue_lat_c2", 64'(csr_req_valid), 64'(1));
        do_cmd(1'b0, 3'd3, 32'h0, 2);
        wait_idle("wr_rd");

        // FIFO full with the responder stalled, then in-order drain
        hold_req = 1'b1;
        for (int i = 0; i < 5; i++) do_cmd(1'b1, 3'(i), $urandom, 0);
        check("full_ready_low", 64'(host_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("full_ready_stays_low", 64'(host_ready), 64'(0));
        hold_req = 1'b0;
        wait_idle("fifo_full");
        for (int i = 0; i < 5; i++) do_cmd(1'b0, 3'(i), 32'h0, $urandom_range(1, 4));
        wait_idle("fifo_readback");

        // timeout, then a stray reply 20 cycles later
        do_cmd(1'b0, 3'd5, 32'h0, TO + 20);
        wait_idle("timeout");
        check("timeout_stray_one", 64'(stray_cnt), 64'(1));

        // reply exactly in the timeout cycle
        do_cmd(1'b1, 3'd6, 32'h1234, 0);
        do_cmd(1'b0, 3'd6, 32'h0, TO);
        wait_idle("edge_rsp");

        // host backpressure while a stray reply is pending
        sink_block = 1'b1;
        do_cmd(1'b0, 3'd2, 32'h0, TO + 2);
        do_cmd(1'b1, 3'd1, $urandom, 0);
        r = 0;
        while (!host_rsp_valid && r < 100) begin @(posedge clk); #1; r++; end
        check("bp_rsp_seen", 64'(host_rsp_valid), 64'(1));
        repeat (10) @(posedge clk);
        #1;
        sink_block = 1'b0;
        wait_idle("backpressure");

        // randomized traffic
        rand_sink = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) dly = $urandom_range(1, TO);
            else if (r == 7) dly = TO;
            else dly = $urandom_range(TO + 1, 30);
            do_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, dly);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle("random");
        rand_sink = 1'b0;

        // reset while a request is pending and two commands are queued
        hold_req = 1'b1;
        snap = model_mem;
        for (int i = 0; i < 3; i++) do_cmd(1'b1, 3'(i), $urandom, 0);
        check("pre_rst_req_valid", 64'(csr_req_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_drops_req_valid", 64'(csr_req_valid), 64'(0));
        check("rst_drops_rsp_valid", 64'(host_rsp_valid), 64'(0));
        exp_req_q.delete(); exp_rsp_q.delete(); exp_lat_q.delete(); delay_q.delete();
        model_mem = snap;
        exp_stray = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_host_ready", 64'(host_ready), 64'(1));
        check("post_rst_stray", 64'(stray_cnt), 64'(0));
        hold_req = 1'b0;
        do_cmd(1'b0, 3'd3, 32'h0, 3);
        wait_idle("post_rst");

        check("exp_req_drained", 64'(exp_req_q.size()), 64'(0));
        check("exp_rsp_drained", 64'(exp_rsp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dev_csr_initiator.md
Name: dev_csr_initiator

Overview:
- Initiator (requester) side of the dev CSR manager interface: accepts host CSR commands, issues them on the csr_* request channel and returns read data to the host.
- Used by dev testbench harnesses and control tiles to program dev accelerator CSR blocks.
- Buffers commands in a small FIFO and keeps at most one transaction outstanding, so responses return in order.
- A response timeout guards against a hung responder.

Parameters:
- RegCount, 8, number of CSR registers addressable in the target.
- RegDataWidth, 32, CSR data width.
- RegAddrWidth, $clog2(RegCount), CSR address width.
- CmdDepth, 4, command FIFO depth; power of two, minimum 2.
- TimeoutCycles, 255, WAIT_RSP cycle limit; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- host_addr_i  in  RegAddrWidth  command address.
- host_wr_data_i  in  RegDataWidth  command write data.
- host_wr_en_i  in  1  1 = write, 0 = read.
- host_valid_i  in  1  command valid.
- host_ready_o  out  1  command FIFO not full.
- host_rd_data_o  out  RegDataWidth  read response data.
- host_rsp_err_o  out  1  response is a timeout error.
- host_rsp_valid_o  out  1  read response valid.
- host_rsp_ready_i  in  1  host accepts the response.
- csr_addr_o  out  RegAddrWidth  request address.
- csr_wr_data_o  out  RegDataWidth  request write data.
- csr_wr_en_o  out  1  request write enable.
- csr_req_valid_o  out  1  request valid.
- csr_req_ready_i  in  1  responder accepts the request.
- csr_rd_data_i  in  RegDataWidth  responder read data.
- csr_rsp_valid_i  in  1  responder response valid.
- csr_rsp_ready_o  out  1  initiator accepts the response.
- busy_o  out  1  FIFO non-empty or FSM not in IDLE.
- stray_cnt_o  out  8  saturating count of responses received outside WAIT_RSP.

Behaviour:
- Single clock domain; clock clk_i; asynchronous active-low reset rst_ni.
- Reset values: all outputs 0 except host_ready_o = 1 and csr_rsp_ready_o = 1. FIFO empty, FSM in IDLE, counters 0.
- Reset asserted mid-operation drops csr_req_valid_o and host_rsp_valid_o immediately (asynchronously); pending commands are discarded.
- Host push: occurs when host_valid_i & host_ready_o.
  - host_ready_o = !full.
  - When the FIFO is full, a pop in the same cycle does not re-open ready.
- FSM states: IDLE, REQ, WAIT_RSP, HOST_RSP.
- IDLE: if FIFO non-empty, pop the head into the request register and go to REQ.
- Latency: csr_req_valid_o rises 2 cycles after the host handshake when the FIFO was empty.
- REQ:
  - csr_req_valid_o = 1; csr_addr_o, csr_wr_data_o and csr_wr_en_o come from the request register and are held stable until the handshake.
  - On csr_req_ready_i: a write goes to IDLE (writes produce no response); a read goes to WAIT_RSP and clears the timeout counter.
- WAIT_RSP:
  - On csr_rsp_valid_i: capture csr_rd_data_i, set err = 0, go to HOST_RSP.
  - Otherwise increment the counter. If TimeoutCycles != 0 and the counter == TimeoutCycles-1: set data = 0, err = 1, go to HOST_RSP.
  - A response in the timeout cycle takes precedence over the timeout.
- HOST_RSP:
  - host_rsp_valid_o = 1; host_rd_data_o and host_rsp_err_o held stable.
  - On host_rsp_ready_i go to IDLE. The next command is popped on the following cycle, not in the same cycle.
- csr_rsp_ready_o = 1 in every state except HOST_RSP.
- A response accepted in IDLE or REQ, for example a late response after a timeout, is discarded and increments stray_cnt_o. The count saturates at 255.
- FIFO pointers are log2(CmdDepth)+1 bits wide; full/empty are resolved by the MSB compare, and pointers wrap naturally.
- Push and pop in the same cycle on a non-full FIFO are both performed.

Decomposition:
- Package dev_csr_pkg holds:
  - csr_cmd_t struct {addr, wr_data, wr_en}, parameterised via localparams matching the defaults.
  - csr_init_state_e enum {IDLE, REQ, WAIT_RSP, HOST_RSP}.
  - STRAY_CNT_W = 8.
- Sub-module dev_csr_cmd_fifo: generic synchronous FIFO of csr_cmd_t with push, pop, full, empty.
- dev_csr_initiator instantiates dev_csr_cmd_fifo and contains the FSM, request/response registers and counters.

Test Plan:
- Write, then read back:
  - Stimulus: write addr 3, data 0xDEADBEEF; then read addr 3. Responder has 1-cycle req_ready and replies 0xDEADBEEF 2 cycles after the read handshake.
  - Required: the read request appears on csr_* only after the write handshake; host_rd_data_o = 0xDEADBEEF with err = 0; busy_o returns to 0.
- FIFO full and in-order issue:
  - Stimulus: hold csr_req_ready_i = 0 and push 5 commands with CmdDepth = 4.
  - Required: after 4 pushes plus 1 popped into REQ, host_ready_o deasserts at the 6th attempt. Releasing ready issues addresses 0..4 in order.
- Timeout:
  - Stimulus: TimeoutCycles = 8; read addr 5; responder never replies.
  - Required: host_rsp_valid_o 8 cycles after the req handshake with data 0 and err = 1. A reply 20 cycles later is accepted in IDLE and stray_cnt_o = 1.
- Response in the timeout cycle:
  - Stimulus: TimeoutCycles = 8; responder replies 0x1234 exactly in the 8th WAIT_RSP cycle.
  - Required: data 0x1234, err = 0, stray_cnt_o = 0.
- Host backpressure:
  - Stimulus: host_rsp_ready_i = 0 for 10 cycles during HOST_RSP while the responder asserts a stray csr_rsp_valid_i.
  - Required: csr_rsp_ready_o = 0, host outputs stable, no new request issued. After ready, the next command issues 2 cycles later.
- Reset mid-operation:
  - Stimulus: assert rst_ni low while in REQ with 2 commands queued.
  - Required: csr_req_valid_o = 0 in the same cycle; after release, busy_o = 0 and host_ready_o = 1.
